// File: rtl/mem_arb_pkg.sv
// Shared types and small decode helpers for the data-memory arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD_RESP, RMW_WR, DONE} arb_state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} mem_size_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LSU = 1'b1} arb_owner_t;

    // Size code 3 has no meaning of its own and is folded onto a full word.
    function automatic mem_size_t decode_size(input logic [1:0] size);
        mem_size_t result;
        case (size)
            2'd0:    result = SZ_B;
            2'd1:    result = SZ_H;
            default: result = SZ_W;
        endcase
        return result;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        logic result;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = offset[0];
            default: result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// lane_align: merges sub-word store data into a memory word and extracts/extends sub-word load data.
module lane_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    mem_size_t   sz;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sz = mem_size_t'(size);

    always_comb begin
        merged = mem_word;
        case (sz)
            SZ_B:    merged[{offset, 3'b000} +: 8] = data[7:0];
            SZ_H:    merged[{offset[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
    end

    // The extension bit is forced low for lbu/lhu, otherwise it copies the lane's MSB.
    always_comb begin
        lane_b    = mem_word[{offset, 3'b000} +: 8];
        lane_h    = mem_word[{offset[1], 4'b0000} +: 16];
        extracted = mem_word;
        case (sz)
            SZ_B:    extracted = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
            SZ_H:    extracted = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
            default: extracted = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read data memory between fetch and load/store, with RMW for sub-word stores.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [1:0]    lsu_size,
    input  logic          lsu_unsigned,
    input  logic [AW-1:0] lsu_addr,
    input  logic [31:0]   lsu_wdata,
    output logic          lsu_gnt,
    output logic          lsu_rvalid,
    output logic [31:0]   lsu_rdata,
    output logic          lsu_err,
    output logic [MW-1:0] mem_addr,
    output logic          mem_r_enable,
    output logic          mem_w_enable,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    arb_state_t    state, state_next;
    arb_owner_t    owner;
    logic [MW-1:0] addr_q;
    logic [1:0]    offset_q;
    mem_size_t     size_q;
    logic          unsigned_q;
    logic          err_q;
    logic [31:0]   wdata_q;

    mem_size_t     lsu_sz;
    logic          lsu_misaligned;
    logic          pick_lsu, pick_if;
    logic [31:0]   merged, extracted;
    logic          unused;

    assign lsu_sz         = decode_size(lsu_size);
    assign lsu_misaligned = is_misaligned(lsu_sz, lsu_addr[1:0]);
    assign unused         = ^{if_addr[AW-1:MW+2], if_addr[1:0], lsu_addr[AW-1:MW+2]};

`ifdef MEM_ARB_RR_EN
    arb_owner_t favour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favour <= OWN_LSU;
        end else if (pick_lsu) begin
            favour <= OWN_IF;
        end else if (pick_if) begin
            favour <= OWN_LSU;
        end
    end
`endif

    // Grants are suppressed while reset is held so every output reads zero during reset.
    always_comb begin
        pick_lsu = 1'b0;
        pick_if  = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
            pick_lsu = lsu_req && (!if_req || favour == OWN_LSU);
`else
            pick_lsu = lsu_req;
`endif
            pick_if  = if_req && !pick_lsu;
        end
    end

    always_comb begin
        state_next   = state;
        if_gnt       = pick_if;
        lsu_gnt      = pick_lsu;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = '0;
        lsu_err      = 1'b0;
        mem_addr     = '0;
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                if (pick_lsu) begin
                    if (lsu_misaligned) begin
                        state_next = DONE;
                    end else if (!lsu_we) begin
                        mem_addr     = lsu_addr[MW+1:2];
                        mem_r_enable = 1'b1;
                        state_next   = RD_RESP;
                    end else if (lsu_sz == SZ_W) begin
                        mem_addr     = lsu_addr[MW+1:2];
                        mem_w_enable = 1'b1;
                        mem_wdata    = lsu_wdata;
                        state_next   = DONE;
                    end else begin
                        mem_addr     = lsu_addr[MW+1:2];
                        mem_r_enable = 1'b1;
                        state_next   = RMW_WR;
                    end
                end else if (pick_if) begin
                    mem_addr     = if_addr[MW+1:2];
                    mem_r_enable = 1'b1;
                    state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (owner == OWN_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end else begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = extracted;
                end
                state_next = IDLE;
            end
            RMW_WR: begin
                mem_addr     = addr_q;
                mem_w_enable = 1'b1;
                mem_wdata    = merged;
                state_next   = DONE;
            end
            DONE: begin
                lsu_rvalid = 1'b1;
                lsu_err    = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured at grant because the requester may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            addr_q     <= '0;
            offset_q   <= 2'b00;
            size_q     <= SZ_W;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state <= state_next;
            if (pick_lsu) begin
                owner      <= OWN_LSU;
                addr_q     <= lsu_addr[MW+1:2];
                offset_q   <= lsu_addr[1:0];
                size_q     <= lsu_sz;
                unsigned_q <= lsu_unsigned;
                err_q      <= lsu_misaligned;
                wdata_q    <= lsu_wdata;
            end else if (pick_if) begin
                owner <= OWN_IF;
                err_q <= 1'b0;
            end
        end
    end

    lane_align u_lane_align (
        .mem_word    (mem_rdata),
        .data        (wdata_q),
        .size        (size_q),
        .offset      (offset_q),
        .is_unsigned (unsigned_q),
        .merged      (merged),
        .extracted   (extracted)
    );

endmodule
